// File: rtl/riscv_defs.sv
// Shared RV32I load/store definitions: funct3 width encodings and LSU FSM states.
package riscv_defs;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering for the LSU: store byte enables and replication, load
// lane extraction with sign/zero extension, and misalignment/illegal decode.
module lsu_data_align
    import riscv_defs::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a latch behind.
        be         = 4'b0000;
        wdata_rep  = wdata;
        rdata_ext  = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        byte_lane  = rdata[{offset, 3'b000} +: 8];
        half_lane  = offset[1] ? rdata[31:16] : rdata[15:0];

        unique case (funct3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = funct3[2] ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            end
            F3_H, F3_HU: begin
                be         = offset[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = offset[0];
                rdata_ext  = funct3[2] ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
            end
            F3_W: begin
                be         = 4'b1111;
                misaligned = |offset;
                rdata_ext  = rdata;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access on a req/gnt/rvalid data-memory port.
// Misaligned or illegal requests and responder timeouts complete with rsp_err.
module load_store_unit
    import riscv_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e    state_q;
    logic [CW-1:0] tmo_cnt_q;
    logic [2:0]    funct3_q;
    logic [1:0]    offset_q;
    logic          mem_req_q, mem_we_q;
    logic [31:0]   mem_addr_q, mem_wdata_q;
    logic [3:0]    mem_be_q;
    logic          rsp_valid_q, rsp_err_q;
    logic [31:0]   rsp_rdata_q;

    logic          idle, accept, req_err, timeout;
    logic [2:0]    al_funct3;
    logic [1:0]    al_offset;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata_rep, al_rdata_ext;
    logic          al_misaligned, al_illegal;

    assign idle      = (state_q == IDLE);
    assign req_ready = idle;
    assign accept    = req_valid && idle && (req_is_load || req_is_store);
    // Stores have no unsigned variants, so the BU/HU encodings are legal only for loads.
    assign req_err   = (req_is_load && req_is_store) || al_illegal || al_misaligned
                     || (req_is_store && req_funct3[2]);
    assign timeout   = (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Request side decodes the live inputs; response side the captured request.
    assign al_funct3 = idle ? req_funct3 : funct3_q;
    assign al_offset = idle ? req_addr[1:0] : offset_q;

    lsu_data_align u_align (
        .funct3     (al_funct3),
        .offset     (al_offset),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .be         (al_be),
        .wdata_rep  (al_wdata_rep),
        .rdata_ext  (al_rdata_ext),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tmo_cnt_q   <= '0;
            funct3_q    <= '0;
            offset_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: if (accept) begin
                    tmo_cnt_q   <= '0;
                    funct3_q    <= req_funct3;
                    offset_q    <= req_addr[1:0];
                    mem_we_q    <= req_is_store;
                    mem_addr_q  <= {req_addr[31:2], 2'b00};
                    mem_be_q    <= al_be;
                    mem_wdata_q <= al_wdata_rep;
                    rsp_rdata_q <= '0;
                    if (req_err) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    tmo_cnt_q <= tmo_cnt_q + CW'(1);
                    if (timeout) begin
                        mem_req_q   <= 1'b0;
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end else if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    tmo_cnt_q <= tmo_cnt_q + CW'(1);
                    if (timeout) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end else if (mem_rvalid) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= mem_we_q ? '0 : al_rdata_ext;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver plays core and memory responder,
// an independent monitor checks every completion against a byte-level model.
module tb_load_store_unit;
    import riscv_defs::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_is_load, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    logic [2:0] ld_f3 [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    logic [2:0] st_f3 [3] = '{F3_B, F3_H, F3_W};

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_load  (req_is_load),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: access size in bytes, lane shift, mask and extend.
    function automatic void model(input bit ld, input bit st, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] rd, output bit err,
                                  output logic [3:0] be, output logic [31:0] wrep,
                                  output logic [31:0] rext);
        int size, o;
        bit legal;
        logic [31:0] mask, v;
        o     = int'(addr % 4);
        size  = 1 << f3[1:0];
        legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        err   = (ld && st) || !legal || ((o % size) != 0);
        be    = 4'(((1 << size) - 1) << o);
        mask  = (size == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * size)) - 1);
        if (size == 1)      wrep = (wd & 32'hFF) * 32'h0101_0101;
        else if (size == 2) wrep = (wd & 32'hFFFF) * 32'h0001_0001;
        else                wrep = wd;
        v = (rd >> (8 * o)) & mask;
        if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
        rext = st ? 32'h0 : v;
    endfunction

    // g / r: cycle (1 = first cycle after accept) in which gnt / rvalid are driven.
    task automatic run_txn(input bit ld, input bit st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int g, input int r,
                           input bit late_rv);
        bit err, tmo;
        logic [3:0] be;
        logic [31:0] wrep, rext;
        int rsp_at, req_last;
        exp_t e;
        model(ld, st, f3, addr, wd, rd, err, be, wrep, rext);
        tmo      = !err && (g >= TMO || r >= TMO);
        rsp_at   = err ? 1 : (tmo ? TMO + 1 : r + 1);
        req_last = err ? 0 : ((g < TMO) ? g : TMO);

        @(negedge clk);
        check("req_ready idle", {31'b0, req_ready}, 32'd1);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        req_valid = 1'b1; req_is_load = ld; req_is_store = st;
        req_funct3 = f3; req_addr = addr; req_wdata = wd;
        e.err   = err || tmo;
        e.rdata = (err || tmo) ? 32'h0 : rext;
        e.cyc   = cyc + rsp_at;
        exp_q.push_back(e);

        for (int c = 1; c <= rsp_at; c++) begin
            @(negedge clk);
            req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
            req_addr = $urandom(); req_wdata = $urandom();
            check("req_ready busy", {31'b0, req_ready}, 32'd0);
            check("mem_req", {31'b0, mem_req}, {31'b0, (c <= req_last)});
            if (c <= req_last) begin
                check("mem_we", {31'b0, mem_we}, {31'b0, st});
                check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                check("mem_be", {28'b0, mem_be}, {28'b0, be});
                if (st) check("mem_wdata", mem_wdata, wrep);
            end
            mem_gnt    = !err && (c == g) && (c <= TMO);
            mem_rvalid = !err && (c == r) && (r > g) && (c <= TMO);
            mem_rdata  = mem_rvalid ? rd : $urandom();
        end
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = late_rv; mem_rdata = $urandom();
    endtask

    task automatic run_none();
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        req_valid = 1'b1; req_is_load = 1'b0; req_is_store = 1'b0;
        req_funct3 = 3'($urandom_range(0, 7)); req_addr = $urandom();
        repeat (2) begin
            @(negedge clk);
            check("ready after no-op", {31'b0, req_ready}, 32'd1);
            check("mem_req after no-op", {31'b0, mem_req}, 32'd0);
        end
        req_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
        check({tag, " rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, " rsp_err"}, {31'b0, rsp_err}, 32'd0);
        check({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, " mem_req"}, {31'b0, mem_req}, 32'd0);
        check({tag, " mem_we"}, {31'b0, mem_we}, 32'd0);
        check({tag, " mem_addr"}, mem_addr, 32'd0);
        check({tag, " mem_be"}, {28'b0, mem_be}, 32'd0);
        check({tag, " mem_wdata"}, mem_wdata, 32'd0);
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("rsp_valid unexpected", {31'b0, rsp_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_txn(1, 0, F3_W,  32'h10, 32'h0, 32'hDEAD_BEEF, 1, 2, 0);
        run_txn(1, 0, F3_B,  32'h13, 32'h0, 32'h80FF_0000, 1, 2, 0);
        run_txn(1, 0, F3_BU, 32'h13, 32'h0, 32'h80FF_0000, 1, 2, 0);
        run_txn(0, 1, F3_H,  32'h22, 32'h1234_ABCD, 32'h5555_5555, 4, 6, 0);
        run_txn(0, 1, F3_B,  32'h41, 32'hCAFE_F00D, 32'h0, 2, 3, 0);
        run_txn(1, 0, F3_HU, 32'h82, 32'h0, 32'h8001_7FFF, 1, 3, 0);
        run_txn(1, 0, F3_H,  32'h82, 32'h0, 32'h8001_7FFF, 1, 3, 0);
        run_txn(1, 0, F3_W,  32'h06, 32'h0, 32'h0, 1, 2, 0);
        run_txn(1, 0, F3_H,  32'h05, 32'h0, 32'h0, 1, 2, 0);
        run_txn(1, 1, F3_W,  32'h20, 32'h0, 32'h0, 1, 2, 0);
        run_txn(0, 1, F3_BU, 32'h20, 32'h0, 32'h0, 1, 2, 0);
        run_txn(1, 0, 3'b011, 32'h20, 32'h0, 32'h0, 1, 2, 0);
        run_txn(1, 0, F3_W,  32'h30, 32'h0, 32'h1111_1111, 99, 100, 1);
        run_txn(1, 0, F3_W,  32'h34, 32'h0, 32'h2222_2222, 1, 2, 0);
        run_txn(1, 0, F3_W,  32'h38, 32'h0, 32'h3333_3333, 14, 15, 0);
        run_txn(1, 0, F3_W,  32'h3C, 32'h0, 32'h4444_4444, 14, 16, 1);
        run_txn(0, 1, F3_W,  32'h40, 32'h7777_7777, 32'h0, 16, 17, 0);
        run_none();

        // Reset while waiting for rvalid, then a stale rvalid in IDLE
        @(negedge clk);
        mem_rvalid = 1'b0;
        req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0;
        req_funct3 = F3_W; req_addr = 32'h50;
        @(negedge clk);
        req_valid = 1'b0; req_is_load = 1'b0;
        check("mem_req before reset", {31'b0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("ready after stale rvalid", {31'b0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        run_txn(1, 0, F3_W, 32'h54, 32'h0, 32'h600D_600D, 1, 2, 0);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            bit ld, st;
            logic [2:0] f3;
            logic [31:0] addr;
            int g, r, sel;
            sel = $urandom_range(0, 19);
            if (sel == 1) begin
                run_none();
            end else begin
                ld = 1'($urandom_range(0, 1));
                st = !ld;
                if (sel == 0) begin ld = 1'b1; st = 1'b1; end
                f3 = ld ? ld_f3[$urandom_range(0, 4)] : st_f3[$urandom_range(0, 2)];
                if (sel == 2) f3 = 3'($urandom_range(0, 7));
                addr = $urandom();
                if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
                g = (sel == 3) ? $urandom_range(13, 18) : $urandom_range(1, 4);
                r = g + ((sel == 4) ? $urandom_range(1, 20) : $urandom_range(1, 3));
                run_txn(ld, st, f3, addr, $urandom(), $urandom(), g, r, (sel == 5));
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
